// File: rtl/idct_pkg.sv
// Shared constants, read-FSM state type and pixel saturation for the
// idct2d result sink.
//   BLK_SIZE  samples per 8x8 block
//   ADDR_W    sample address width (raster row*8+col)
//   COEF_W    signed sample width from idct2d
//   PIX_W     output pixel width
package idct_pkg;

   localparam int BLK_SIZE = 64;
   localparam int ADDR_W   = 6;
   localparam int COEF_W   = 16;
   localparam int PIX_W    = 8;

   localparam logic signed [COEF_W:0] PIX_MAX = (COEF_W+1)'(2**PIX_W - 1);

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_STREAM
   } rd_state_e;

   // Sample plus bias in COEF_W+1 bits so the sum cannot wrap, then clamp
   // to the unsigned pixel range.
   function automatic logic [PIX_W-1:0] saturate(input logic [COEF_W-1:0]   sample,
                                                 input logic signed [COEF_W:0] bias);
      logic signed [COEF_W:0] s;
      s = $signed({sample[COEF_W-1], sample}) + bias;
      if (s[COEF_W])
         return '0;
      else if (s > PIX_MAX)
         return '1;
      else
         return s[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/idct_block_sink_if.sv
// Pixel stream from the block sink to the frame-store writer.
//   out_data   saturated pixel
//   out_valid  out_data valid
//   out_ready  downstream accepts
//   out_last   high with the final sample of a block
// master = sink side, slave = frame-store writer side.
interface idct_block_sink_if;
   import idct_pkg::*;

   logic [PIX_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/idct_bank_ram.sv
// Ping-pong sample storage: two banks of BLK_SIZE x COEF_W.
//   clk                         clock
//   we, wr_bank, wr_addr, wr_data   write port
//   re, rd_bank, rd_addr        read request
//   rd_data                     registered read data, holds when re is low
module idct_bank_ram
   import idct_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              re,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COEF_W-1:0] rd_data
);

   logic [COEF_W-1:0] mem [2*BLK_SIZE];

   always_ff @(posedge clk) begin
      if (we)
         mem[{wr_bank, wr_addr}] <= wr_data;
      if (re)
         rd_data <= mem[{rd_bank, rd_addr}];
   end

endmodule

// File: rtl/idct_block_sink.sv
// Captures idct2d result blocks into ping-pong banks and streams each
// completed block out as saturated pixels in raster order.
//   clk, reset            clock, async active-high reset
//   waddr, wdata, wwren   idct2d result write port
//   idct_rdy              idct2d rdy; rising edge completes the block
//   sink_full             bank targeted by writes is full
//   overflow              sticky: write or completion hit a full bank
//   blk_cnt               blocks fully streamed out (wraps)
//   out_if                pixel stream (master)
//
// state    | meaning
// R_IDLE   | waiting for bank rd_sel to fill; read of sample 0 issued on exit
// R_FETCH  | sample 0 arriving from RAM; next sample prefetched
// R_STREAM | out_valid high; each handshake loads prefetched sample
module idct_block_sink
   import idct_pkg::*;
#(
   parameter int BIAS  = 0,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [COEF_W-1:0] wdata,
   input  logic              wwren,
   input  logic              idct_rdy,
   output logic              sink_full,
   output logic              overflow,
   output logic [CNT_W-1:0]  blk_cnt,
   idct_block_sink_if.master out_if
);

   localparam logic signed [COEF_W:0] BIAS_S   = (COEF_W+1)'(BIAS);
   localparam logic [ADDR_W-1:0]      LAST_IDX = ADDR_W'(BLK_SIZE - 1);

   rd_state_e         state_q, state_d;
   logic              wr_sel_q, wr_sel_d;
   logic [1:0]        full_q, full_d;
   logic              rdy_q, rdy_d;
   logic              overflow_q, overflow_d;
   logic              rd_sel_q, rd_sel_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [PIX_W-1:0]  out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

   logic              done, hs, wr_blocked;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_raddr;
   logic [COEF_W-1:0] ram_rdata;

   idct_bank_ram u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_bank (wr_sel_q),
      .wr_addr (waddr),
      .wr_data (wdata),
      .re      (ram_re),
      .rd_bank (rd_sel_q),
      .rd_addr (ram_raddr),
      .rd_data (ram_rdata)
   );

   always_comb begin
      done        = idct_rdy & ~rdy_q;
      hs          = out_valid_q & out_if.out_ready;
      wr_blocked  = full_q[wr_sel_q];
      ram_we      = wwren & ~wr_blocked;
      ram_re      = 1'b0;
      ram_raddr   = '0;
      state_d     = state_q;
      wr_sel_d    = wr_sel_q;
      full_d      = full_q;
      rdy_d       = idct_rdy;
      overflow_d  = overflow_q | (wr_blocked & (wwren | done));
      rd_sel_d    = rd_sel_q;
      rd_idx_d    = rd_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      blk_cnt_d   = blk_cnt_q;

      case (state_q)
         R_IDLE: begin
            if (full_q[rd_sel_q]) begin
               ram_re  = 1'b1;
               state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            // RAM output register holds sample 0; fetch sample 1 behind it.
            ram_re      = 1'b1;
            ram_raddr   = ADDR_W'(1);
            out_data_d  = saturate(ram_rdata, BIAS_S);
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            rd_idx_d    = '0;
            state_d     = R_STREAM;
         end
         R_STREAM: begin
            if (hs) begin
               if (out_last_q) begin
                  full_d[rd_sel_q] = 1'b0;
                  rd_sel_d         = ~rd_sel_q;
                  blk_cnt_d        = blk_cnt_q + 1'b1;
                  out_valid_d      = 1'b0;
                  out_last_d       = 1'b0;
                  state_d          = R_IDLE;
               end else begin
                  // RAM already holds rd_idx+1; fetch rd_idx+2 (wraps harmlessly at the end).
                  ram_re     = 1'b1;
                  ram_raddr  = rd_idx_q + ADDR_W'(2);
                  out_data_d = saturate(ram_rdata, BIAS_S);
                  rd_idx_d   = rd_idx_q + 1'b1;
                  out_last_d = (rd_idx_q + 1'b1) == LAST_IDX;
               end
            end
         end
         default: state_d = R_IDLE;
      endcase

      // The write bank can never be the bank being drained here: a drain
      // implies that bank is full, and completion requires the target empty.
      if (done & ~wr_blocked) begin
         full_d[wr_sel_q] = 1'b1;
         wr_sel_d         = ~wr_sel_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= R_IDLE;
         wr_sel_q    <= 1'b0;
         full_q      <= '0;
         rdy_q       <= 1'b1;
         overflow_q  <= 1'b0;
         rd_sel_q    <= 1'b0;
         rd_idx_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         blk_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_sel_q    <= wr_sel_d;
         full_q      <= full_d;
         rdy_q       <= rdy_d;
         overflow_q  <= overflow_d;
         rd_sel_q    <= rd_sel_d;
         rd_idx_q    <= rd_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         blk_cnt_q   <= blk_cnt_d;
      end
   end

   assign sink_full        = full_q[wr_sel_q];
   assign overflow         = overflow_q;
   assign blk_cnt          = blk_cnt_q;
   assign out_if.out_data  = out_data_q;
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_idct_block_sink.sv
// Bench for idct_block_sink. The reference model treats the sink as a
// two-deep FIFO of blocks: a block is accepted only if fewer than two
// blocks are held, writes/completions with two held raise overflow, and
// accepted blocks come out as clamped pixels in write order.
module tb_idct_block_sink;

   localparam int BIAS  = 0;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [5:0]       waddr = '0;
   logic [15:0]      wdata = '0;
   logic             wwren = 1'b0;
   logic             idct_rdy = 1'b1;
   logic             sink_full;
   logic             overflow;
   logic [CNT_W-1:0] blk_cnt;

   idct_block_sink_if out_if ();

   idct_block_sink #(.BIAS(BIAS), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .waddr     (waddr),
      .wdata     (wdata),
      .wwren     (wwren),
      .idct_rdy  (idct_rdy),
      .sink_full (sink_full),
      .overflow  (overflow),
      .blk_cnt   (blk_cnt),
      .out_if    (out_if)
   );

   always #5 clk = ~clk;

   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   int  occ = 0;          // blocks held (completed, not fully streamed)
   int  exp_blk = 0;
   bit  exp_ovf = 1'b0;
   int  exp_q[$];
   int  fv[$];            // cycle each block's first sample became valid
   int  lh[$];            // cycle of each block's final handshake
   int  mon_idx = 0;
   bit  seen_first = 1'b0;
   bit  stall = 1'b0;
   logic [7:0] held_data = '0;
   logic       held_last = 1'b0;
   int  ready_mode = 0;   // 0 hold, 1 toggle, 2 random
   int  done_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int ref_pix(input logic [15:0] w);
      int v;
      v = int'($signed(w)) + BIAS;
      if (v < 0)   return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   // Output monitor: samples half a cycle before the edge that would
   // complete a handshake.
   always @(negedge clk) begin
      if (reset) begin
         mon_idx    = 0;
         seen_first = 1'b0;
         stall      = 1'b0;
      end else begin
         chk("sink_full", 32'(sink_full), 32'(occ == 2));
         chk("overflow", 32'(overflow), 32'(exp_ovf));
         chk("blk_cnt", 32'(blk_cnt), 32'(exp_blk));
         if (stall) begin
            chk("hold_valid", 32'(out_if.out_valid), 32'd1);
            chk("hold_data", 32'(out_if.out_data), 32'(held_data));
            chk("hold_last", 32'(out_if.out_last), 32'(held_last));
         end
         if (out_if.out_valid && !seen_first) begin
            fv.push_back(cyc);
            seen_first = 1'b1;
         end
         if (out_if.out_valid && out_if.out_ready) begin
            chk("sample_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
               chk("pixel", 32'(out_if.out_data), 32'(exp_q.pop_front()));
            chk("last", 32'(out_if.out_last), 32'(mon_idx == 63));
            if (mon_idx == 63) begin
               lh.push_back(cyc + 1);
               exp_blk++;
               occ--;
               mon_idx    = 0;
               seen_first = 1'b0;
            end else begin
               mon_idx++;
            end
         end
         stall     = out_if.out_valid && !out_if.out_ready;
         held_data = out_if.out_data;
         held_last = out_if.out_last;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      case (ready_mode)
         1: out_if.out_ready = ~out_if.out_ready;
         2: out_if.out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   // kind 0: addr*5-20; kind 1: random mix of in-range and extreme values.
   task automatic write_block(input int kind, input bit sync_last);
      logic [15:0] d [64];
      int k;
      idct_rdy = 1'b0;
      step();
      for (int i = 0; i < 64; i++) begin
         if (kind == 0)
            d[i] = 16'(i * 5 - 20);
         else if ($urandom_range(0, 3) == 0)
            d[i] = 16'($urandom);
         else
            d[i] = 16'($urandom_range(0, 340) - 40);
         waddr = 6'(i);
         wdata = d[i];
         wwren = 1'b1;
         step();
         if (occ == 2) exp_ovf = 1'b1;
      end
      wwren = 1'b0;
      if (sync_last) begin
         // Complete on the same edge as the previous block's final handshake.
         k = 0;
         while (!(out_if.out_valid && out_if.out_ready && out_if.out_last) && k < 200) begin
            step();
            k++;
         end
         chk("sync_timeout", 32'(k < 200), 32'd1);
      end
      idct_rdy = 1'b1;
      step();
      done_cyc = cyc;
      if (occ < 2) begin
         occ++;
         for (int i = 0; i < 64; i++) exp_q.push_back(ref_pix(d[i]));
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic wait_blocks(input int n, input int budget);
      int k;
      k = 0;
      while (exp_blk < n && k < budget) begin
         step();
         k++;
      end
      chk("drain_count", 32'(exp_blk), 32'(n));
   endtask

   initial begin
      int done_a, k;
      out_if.out_ready = 1'b0;
      #1 reset = 1'b1;

      // Reset with rdy held high: no spurious block afterwards.
      repeat (3) step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rst_valid", 32'(out_if.out_valid), 32'd0);
         chk("rst_data", 32'(out_if.out_data), 32'd0);
         chk("rst_last", 32'(out_if.out_last), 32'd0);
      end
      chk("rst_no_block", 32'(fv.size()), 32'd0);

      // Single ramp block, out_ready high.
      out_if.out_ready = 1'b1;
      ready_mode = 0;
      write_block(0, 1'b0);
      done_a = done_cyc;
      wait_blocks(1, 300);
      chk("ramp_fv_count", 32'(fv.size()), 32'd1);
      chk("ramp_latency", 32'(fv[0] - done_a), 32'd2);
      chk("ramp_throughput", 32'(lh[0] - fv[0]), 32'd64);

      // Backpressure: out_ready toggles every cycle.
      ready_mode = 1;
      write_block(1, 1'b0);
      wait_blocks(2, 400);
      chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);

      // Ping-pong: B completes on the edge A finishes draining.
      ready_mode = 0;
      out_if.out_ready = 1'b1;
      write_block(1, 1'b0);
      done_a = done_cyc;
      write_block(1, 1'b1);
      wait_blocks(4, 300);
      chk("pp_fv_count", 32'(fv.size()), 32'd4);
      chk("pp_a_latency", 32'(fv[2] - done_a), 32'd2);
      chk("pp_b_after_last", 32'(fv[3] - lh[2]), 32'd2);

      // Overflow: two blocks held, third block dropped entirely.
      out_if.out_ready = 1'b0;
      write_block(1, 1'b0);
      write_block(1, 1'b0);
      chk("ovf_sink_full", 32'(sink_full), 32'd1);
      write_block(1, 1'b0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      ready_mode = 2;
      wait_blocks(6, 800);
      chk("ovf_drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a streamed block.
      ready_mode = 0;
      out_if.out_ready = 1'b1;
      write_block(1, 1'b0);
      k = 0;
      while (mon_idx != 30 && k < 200) begin
         step();
         k++;
      end
      chk("mid_reset_reach", 32'(mon_idx), 32'd30);
      reset = 1'b1;
      occ = 0;
      exp_blk = 0;
      exp_ovf = 1'b0;
      exp_q.delete();
      fv.delete();
      lh.delete();
      repeat (2) step();
      chk("mr_valid", 32'(out_if.out_valid), 32'd0);
      chk("mr_sink_full", 32'(sink_full), 32'd0);
      chk("mr_blk_cnt", 32'(blk_cnt), 32'd0);
      chk("mr_overflow", 32'(overflow), 32'd0);
      reset = 1'b0;
      repeat (5) step();
      chk("mr_no_block", 32'(fv.size()), 32'd0);
      write_block(1, 1'b0);
      done_a = done_cyc;
      wait_blocks(1, 300);
      chk("mr_fv_count", 32'(fv.size()), 32'd1);
      chk("mr_latency", 32'(fv[0] - done_a), 32'd2);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/idct_block_sink.md
# idct_block_sink

Consumer for the `idct2d` result write port. It captures the 64 signed 16-bit samples that `idct2d` writes through `waddr`/`wdata`/`wwren` into a ping-pong pair of 64-entry banks. A block is complete on the rising edge of `idct2d`'s `rdy`. Completed blocks are saturated to 8-bit pixels and streamed out in raster order over a valid/ready interface to the frame-store writer.

## Interface
Parameters:
- BIAS, 0, signed value added to each sample before saturation (0 for MPEG2 intra output)
- CNT_W, 16, width of completed-block counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- waddr  in  6  sample address from `idct2d` (raster, row*8+col)
- wdata  in  16  signed sample from `idct2d`
- wwren  in  1  write strobe from `idct2d`
- idct_rdy  in  1  `idct2d` rdy; a 0->1 transition marks block complete
- sink_full  out  1  bank currently targeted by writes is full; controller must not assert `idct2d` en
- out_data  out  8  saturated pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  high with sample 63 of a block
- overflow  out  1  sticky; write or completion arrived while target bank full
- blk_cnt  out  CNT_W  blocks fully streamed out, wraps

## Operation
- Write side: registers wr_sel, full[1:0], rdy_q (reset value 1, so `rdy` already high out of reset is not an edge).
- Write handling: on wwren with full[wr_sel]=0, bank[wr_sel][waddr] <= wdata. If full[wr_sel]=1, the write is dropped and overflow is set.
- Completion: done = idct_rdy & ~rdy_q.
  - On done with full[wr_sel]=0: full[wr_sel] <= 1 and wr_sel toggles.
  - On done with full[wr_sel]=1: the event is ignored and overflow is set.
- Entries not written since the last drain keep stale contents. `idct2d` writes all 64 samples, so no clearing is performed.
- sink_full = full[wr_sel], combinational from registers.
- Read FSM states: R_IDLE, R_FETCH, R_STREAM; rd_sel and rd_idx (6 bits) are registered.
  - R_IDLE: when full[rd_sel], go to R_FETCH and issue a read of addr 0.
  - R_FETCH: the registered RAM output is loaded into the output register; out_valid <= 1; go to R_STREAM.
  - R_STREAM: on out_valid & out_ready, advance rd_idx and prefetch the next sample so streaming sustains 1 sample/cycle.
  - On the handshake with out_last: clear full[rd_sel], toggle rd_sel, increment blk_cnt, out_valid <= 0, go to R_IDLE.
- Saturation: s = sign-extended wdata + BIAS in 17 bits; s<0 -> 0, s>255 -> 255, otherwise s[7:0].
- Simultaneous events:
  - done on one bank in the same cycle as a drain completes on the other bank: both take effect.
  - A drain completing on the bank that sink_full refers to deasserts sink_full the next cycle.
- Reset mid-operation: both banks are marked empty, any in-flight block is lost, and the FSM returns to R_IDLE.

## Timing
- Reset values:
  - Outputs: out_valid 0, out_data 0, out_last 0, sink_full 0, overflow 0, blk_cnt 0.
  - Internal: wr_sel 0, rd_sel 0, rd_idx 0, rdy_q 1.
- Latency: done sampled at edge N sets full at N; out_valid is first high after edge N+2 with sample 0.
- Handshake:
  - While out_valid & ~out_ready, out_data and out_last hold stable.
  - out_valid never drops without a handshake.
- Throughput: with out_ready held high, the 64 samples occupy 64 consecutive cycles.
- Back-to-back blocks: with the other bank already full, the next block's sample 0 is valid 2 cycles after the out_last handshake.
- Write-to-read forwarding is not needed: a bank is read only once it is full, and it is not written while full.

## Structure
- Package idct_pkg holds:
  - BLK_SIZE=64, ADDR_W=6, COEF_W=16, PIX_W=8.
  - Read FSM enum {R_IDLE, R_FETCH, R_STREAM}.
  - The saturate function.
- Sub-module idct_bank_ram: 2x64x16 storage with 1 write port (bank, addr) and 1 registered read port (bank, addr).

## Test plan
- Reset behaviour: reset with idct_rdy held 1, then release -> all outputs at reset values and no spurious block; out_valid stays 0 for 10 cycles.
- Single block with saturation and ordering: write wdata = addr*5-20 to all 64 addresses, then pulse idct_rdy 0->1 with out_ready=1.
  - Pixels arrive in raster order as sat(i*5-20): 0,0,0,0,0,5,…, reaching 255 from i=55.
  - out_last only at i=63; blk_cnt=1.
- Backpressure: toggle out_ready every cycle -> out_data/out_last stable while stalled; all 64 samples delivered exactly once, no duplicates.
- Ping-pong fill while draining: block A completes, and block B is written and completed during A's drain with out_ready=1.
  - B sample 0 is valid 2 cycles after A's out_last handshake; sink_full is never high.
- Overflow: hold out_ready=0 and complete two blocks -> sink_full=1.
  - A third write is dropped and overflow=1.
  - Releasing out_ready drains both blocks intact; sink_full drops after the first out_last.
- Reset mid-stream: assert reset at sample 30 -> out_valid 0 and banks empty. A new block after reset streams from sample 0 with blk_cnt restarting at 0.
